sdc_hc_reg_arbiter: RTL and testbench

//  Shares the single Host Controller memory-map register port (read index / 128-bit read

---
 rtl/sdc_hc_pkg.sv | 21 ++
 rtl/sdc_hc_reg_arbiter_if.sv | 40 ++++
 rtl/sdc_hc_reg_arbiter_rr_pick.sv | 34 +++
 rtl/sdc_hc_reg_arbiter.sv | 166 ++++++++++++++++
 tb/tb_sdc_hc_reg_arbiter.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sdc_hc_pkg.sv
// Shared Host Controller register-port definitions: field widths, attribute codes,
// well-known register indices and the arbiter FSM encoding.
package sdc_hc_pkg;
    localparam int HC_IDX_W = 12;
    localparam int HC_RD_W  = 128;
    localparam int HC_WR_W  = 32;
    localparam int ATTR_W   = 3;

    localparam logic [ATTR_W-1:0] ATTR_RO   = 3'd0;
    localparam logic [ATTR_W-1:0] ATTR_RW   = 3'd1;
    localparam logic [ATTR_W-1:0] ATTR_RW1C = 3'd3;

    localparam logic [HC_IDX_W-1:0] REG_PRESENT_STATE = 12'h024;
    localparam logic [HC_IDX_W-1:0] REG_NORM_INT_STAT = 12'h030;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_GAP  = 2'd2
    } arb_state_e;
endpackage

// File: rtl/sdc_hc_reg_arbiter_if.sv
// Requester-side and host-side signals of the shared HC register port.
// slave = the arbiter, master = requesters plus host register file.
interface sdc_hc_reg_arbiter_if
    import sdc_hc_pkg::*;
#(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]          req;
    logic [NREQ*HC_IDX_W-1:0] req_rd_idx;
    logic [NREQ-1:0]          req_wr_strb;
    logic [NREQ*HC_IDX_W-1:0] req_wr_idx;
    logic [NREQ*HC_WR_W-1:0]  req_wr_data;
    logic [NREQ*ATTR_W-1:0]   req_attr;
    logic [NREQ-1:0]          gnt;
    logic [HC_RD_W-1:0]       rd_data;
    logic [HC_IDX_W-1:0]      rd_reg_index;
    logic [HC_RD_W-1:0]       rd_reg_input;
    logic                     wr_reg_strb;
    logic [HC_IDX_W-1:0]      wr_reg_index;
    logic [HC_WR_W-1:0]       wr_reg_output;
    logic [ATTR_W-1:0]        reg_attr;
    logic [NREQ-1:0]          drop_err;
    logic [NREQ-1:0]          tout_err;
    logic                     err_clr;
    logic                     busy;

    modport slave (
        input  req, req_rd_idx, req_wr_strb, req_wr_idx, req_wr_data, req_attr,
               rd_reg_input, err_clr,
        output gnt, rd_data, rd_reg_index, wr_reg_strb, wr_reg_index, wr_reg_output,
               reg_attr, drop_err, tout_err, busy
    );

    modport master (
        output req, req_rd_idx, req_wr_strb, req_wr_idx, req_wr_data, req_attr,
               rd_reg_input, err_clr,
        input  gnt, rd_data, rd_reg_index, wr_reg_strb, wr_reg_index, wr_reg_output,
               reg_attr, drop_err, tout_err, busy
    );
endinterface

// File: rtl/sdc_hc_reg_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible index at or after i_ptr, wrapping.
module sdc_hc_reg_arbiter_rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_elig,
    input  logic [IW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_onehot,
    output logic [IW-1:0]   o_idx,
    output logic            o_any
);
    // Scan from the farthest candidate back to i_ptr so the nearest eligible one wins
    always_comb begin
        logic [IW:0]   v_sum;
        logic [IW-1:0] v_j;
        v_sum    = '0;
        v_j      = '0;
        o_onehot = '0;
        o_idx    = '0;
        o_any    = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            v_sum = {1'b0, i_ptr} + (IW+1)'(k);
            if (v_sum >= (IW+1)'(NREQ))
                v_sum = v_sum - (IW+1)'(NREQ);
            v_j = v_sum[IW-1:0];
            if (i_elig[v_j]) begin
                o_any         = 1'b1;
                o_idx         = v_j;
                o_onehot      = '0;
                o_onehot[v_j] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/sdc_hc_reg_arbiter.sv
// Round-robin session arbiter for the single HC register port. A grant lasts while the
// owner holds req, is force-revoked after MAX_HOLD cycles, and every grant ends with a
// one-cycle turnaround during which the host port is idle.
module sdc_hc_reg_arbiter
    import sdc_hc_pkg::*;
#(
    parameter int                NREQ     = 4,
    parameter int                HOLD_W   = 16,
    parameter logic [HOLD_W-1:0] MAX_HOLD = 16'd4096
) (
    input  logic                 clk,
    input  logic                 reset,
    sdc_hc_reg_arbiter_if.slave  bus
);
    localparam int IW = $clog2(NREQ);

    arb_state_e          r_state, w_state_nxt;
    logic [IW-1:0]       r_owner, r_rr_ptr;
    logic [HOLD_W-1:0]   r_hold_cnt;
    logic                r_busy;
    logic [NREQ-1:0]     r_gnt, r_lockout, r_drop_err, r_tout_err;
    logic                r_wr_strb;
    logic [HC_IDX_W-1:0] r_rd_idx, r_wr_idx;
    logic [HC_WR_W-1:0]  r_wr_data;
    logic [ATTR_W-1:0]   r_attr;

    logic [NREQ-1:0]     w_elig, w_win_oh, w_own_oh, w_tout_set, w_drop_set;
    logic [IW-1:0]       w_win_idx;
    logic                w_win_any, w_timeout, w_stay;
    logic                w_o_req, w_o_strb;
    logic [HC_IDX_W-1:0] w_o_rd_idx, w_o_wr_idx;
    logic [HC_WR_W-1:0]  w_o_wr_data;
    logic [ATTR_W-1:0]   w_o_attr;

    // A requester locked out by a timeout must drop req once before it can win again
    assign w_elig = bus.req & ~r_lockout;

    sdc_hc_reg_arbiter_rr_pick #(.NREQ(NREQ), .IW(IW)) u_rr_pick (
        .i_elig   (w_elig),
        .i_ptr    (r_rr_ptr),
        .o_onehot (w_win_oh),
        .o_idx    (w_win_idx),
        .o_any    (w_win_any)
    );

    // Mux out the current owner's request slices
    always_comb begin
        w_own_oh    = '0;
        w_o_req     = 1'b0;
        w_o_strb    = 1'b0;
        w_o_rd_idx  = '0;
        w_o_wr_idx  = '0;
        w_o_wr_data = '0;
        w_o_attr    = ATTR_RO;
        for (int i = 0; i < NREQ; i++) begin
            if (r_owner == IW'(i)) begin
                w_own_oh[i] = 1'b1;
                w_o_req     = bus.req[i];
                w_o_strb    = bus.req_wr_strb[i];
                w_o_rd_idx  = bus.req_rd_idx[i*HC_IDX_W +: HC_IDX_W];
                w_o_wr_idx  = bus.req_wr_idx[i*HC_IDX_W +: HC_IDX_W];
                w_o_wr_data = bus.req_wr_data[i*HC_WR_W +: HC_WR_W];
                w_o_attr    = bus.req_attr[i*ATTR_W +: ATTR_W];
            end
        end
    end

    // Next state; a release in the timeout cycle takes priority and raises no error
    always_comb begin
        w_state_nxt = r_state;
        w_timeout   = 1'b0;
        case (r_state)
            ST_IDLE: if (w_win_any) w_state_nxt = ST_OWN;
            ST_OWN: begin
                if (!w_o_req) begin
                    w_state_nxt = ST_GAP;
                end else if (r_hold_cnt == MAX_HOLD - 1'b1) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_GAP;
                end
            end
            ST_GAP:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_stay     = (r_state == ST_OWN) && (w_state_nxt == ST_OWN);
    assign w_tout_set = w_timeout ? w_own_oh : '0;
    assign w_drop_set = bus.req_wr_strb & ~r_gnt;

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Grant, owner, hold counter and round-robin pointer bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            r_gnt      <= '0;
            r_owner    <= '0;
            r_rr_ptr   <= '0;
            r_hold_cnt <= '0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: if (w_win_any) begin
                    r_gnt      <= w_win_oh;
                    r_owner    <= w_win_idx;
                    r_hold_cnt <= '0;
                    r_busy     <= 1'b1;
                end
                ST_OWN: begin
                    if (r_hold_cnt != '1) r_hold_cnt <= r_hold_cnt + 1'b1;
                    if (!w_stay) begin
                        r_gnt  <= '0;
                        r_busy <= 1'b0;
                    end
                end
                ST_GAP: r_rr_ptr <= (r_owner == IW'(NREQ - 1)) ? '0 : r_owner + 1'b1;
                default: ;
            endcase
        end
    end

    // Host port: owner's slices one cycle late while it keeps the grant, idle zeros otherwise
    always_ff @(posedge clk) begin
        if (reset || !w_stay) begin
            r_wr_strb <= 1'b0;
            r_rd_idx  <= '0;
            r_wr_idx  <= '0;
            r_wr_data <= '0;
            r_attr    <= ATTR_RO;
        end else begin
            r_wr_strb <= w_o_strb & w_o_req;
            r_rd_idx  <= w_o_rd_idx;
            r_wr_idx  <= w_o_wr_idx;
            r_wr_data <= w_o_wr_data;
            r_attr    <= w_o_attr;
        end
    end

    // Sticky errors (a new set beats a simultaneous clear) and timeout lockout
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lockout  <= '0;
            r_drop_err <= '0;
            r_tout_err <= '0;
        end else begin
            r_lockout  <= (r_lockout | w_tout_set) & bus.req;
            r_drop_err <= (bus.err_clr ? '0 : r_drop_err) | w_drop_set;
            r_tout_err <= (bus.err_clr ? '0 : r_tout_err) | w_tout_set;
        end
    end

    assign bus.gnt           = r_gnt;
    assign bus.busy          = r_busy;
    assign bus.rd_data       = bus.rd_reg_input;
    assign bus.rd_reg_index  = r_rd_idx;
    assign bus.wr_reg_strb   = r_wr_strb;
    assign bus.wr_reg_index  = r_wr_idx;
    assign bus.wr_reg_output = r_wr_data;
    assign bus.reg_attr      = r_attr;
    assign bus.drop_err      = r_drop_err;
    assign bus.tout_err      = r_tout_err;
endmodule

// File: tb/tb_sdc_hc_reg_arbiter.sv
// Scoreboard bench: each stimulus cycle a session-level reference model predicts the
// outputs following the next clock edge; a monitor pops and compares them.
module tb_sdc_hc_reg_arbiter;
    import sdc_hc_pkg::*;

    localparam int NREQ = 4;
    localparam int MAXH = 8;

    logic clk = 1'b0;
    logic reset;

    sdc_hc_reg_arbiter_if #(.NREQ(NREQ)) ifc ();

    sdc_hc_reg_arbiter #(.NREQ(NREQ), .HOLD_W(16), .MAX_HOLD(16'd8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NREQ-1:0] gnt;
        logic            busy;
        logic            strb;
        logic [11:0]     rd_idx;
        logic [11:0]     wr_idx;
        logic [31:0]     wr_data;
        logic [2:0]      attr;
        logic [NREQ-1:0] drop;
        logic [NREQ-1:0] tout;
        bit              rd_chk;
        logic [127:0]    rd_data;
    } exp_t;

    exp_t q[$];
    int n_chk = 0;
    int n_err = 0;

    // Host register file: read data appears one cycle after the index
    function automatic logic [127:0] host_rd(input logic [11:0] idx);
        logic [127:0] v;
        v     = {8{4'hA, idx}};
        v[16] = (idx == REG_PRESENT_STATE);
        return v;
    endfunction

    always @(posedge clk) ifc.rd_reg_input <= host_rd(ifc.rd_reg_index);

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: who owns the port, whether a turnaround is pending, where the
    // round-robin search starts, and the expected host-side values.
    int              m_owner = -1, m_last = 0, m_next = 0, m_held = 0;
    bit              m_gap = 0, m_idx_known = 0;
    logic [NREQ-1:0] m_locked = '0, m_drop = '0, m_tout = '0;
    logic            m_strb = 0;
    logic [11:0]     m_rd_idx = '0, m_wr_idx = '0;
    logic [31:0]     m_wr_data = '0;
    logic [2:0]      m_attr = '0;

    task automatic model_edge();
        exp_t            e;
        logic [NREQ-1:0] pre_gnt, dset, tset;
        logic [11:0]     prev_idx;
        bit              prev_known;
        int              cand;
        prev_idx   = m_rd_idx;
        prev_known = m_idx_known;
        if (reset) begin
            m_owner = -1; m_gap = 0; m_next = 0; m_held = 0;
            m_locked = '0; m_drop = '0; m_tout = '0;
            m_strb = 0; m_rd_idx = '0; m_wr_idx = '0; m_wr_data = '0; m_attr = '0;
            m_idx_known = 1;
        end else begin
            pre_gnt = '0;
            if (m_owner >= 0) pre_gnt[m_owner] = 1'b1;
            dset = ifc.req_wr_strb & ~pre_gnt;
            tset = '0;
            m_strb = 0; m_rd_idx = '0; m_wr_idx = '0; m_wr_data = '0; m_attr = '0;
            if (m_owner >= 0) begin
                if (!ifc.req[m_owner]) begin
                    m_last = m_owner; m_owner = -1; m_gap = 1;
                end else if (m_held == MAXH - 1) begin
                    tset[m_owner] = 1'b1; m_locked[m_owner] = 1'b1;
                    m_last = m_owner; m_owner = -1; m_gap = 1;
                end else begin
                    m_held++;
                    m_strb    = ifc.req_wr_strb[m_owner];
                    m_rd_idx  = ifc.req_rd_idx[m_owner*12 +: 12];
                    m_wr_idx  = ifc.req_wr_idx[m_owner*12 +: 12];
                    m_wr_data = ifc.req_wr_data[m_owner*32 +: 32];
                    m_attr    = ifc.req_attr[m_owner*3 +: 3];
                end
            end else if (m_gap) begin
                m_gap  = 0;
                m_next = (m_last + 1) % NREQ;
            end else begin
                for (int k = 0; k < NREQ; k++) begin
                    cand = (m_next + k) % NREQ;
                    if (m_owner < 0 && ifc.req[cand] && !m_locked[cand]) begin
                        m_owner = cand; m_held = 0;
                    end
                end
            end
            m_locked = m_locked & ifc.req;
            m_drop   = (ifc.err_clr ? '0 : m_drop) | dset;
            m_tout   = (ifc.err_clr ? '0 : m_tout) | tset;
        end
        e.gnt = '0;
        if (m_owner >= 0) e.gnt[m_owner] = 1'b1;
        e.busy    = (m_owner >= 0);
        e.strb    = m_strb;
        e.rd_idx  = m_rd_idx;
        e.wr_idx  = m_wr_idx;
        e.wr_data = m_wr_data;
        e.attr    = m_attr;
        e.drop    = m_drop;
        e.tout    = m_tout;
        e.rd_chk  = prev_known;
        e.rd_data = host_rd(prev_idx);
        q.push_back(e);
    endtask

    // Monitor: compares DUT outputs shortly after each active edge
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("gnt",      128'(ifc.gnt),           128'(e.gnt));
                check("busy",     128'(ifc.busy),          128'(e.busy));
                check("wr_strb",  128'(ifc.wr_reg_strb),   128'(e.strb));
                check("rd_index", 128'(ifc.rd_reg_index),  128'(e.rd_idx));
                check("wr_index", 128'(ifc.wr_reg_index),  128'(e.wr_idx));
                check("wr_data",  128'(ifc.wr_reg_output), 128'(e.wr_data));
                check("attr",     128'(ifc.reg_attr),      128'(e.attr));
                check("drop_err", 128'(ifc.drop_err),      128'(e.drop));
                check("tout_err", 128'(ifc.tout_err),      128'(e.tout));
                if (e.rd_chk) check("rd_data", ifc.rd_data, e.rd_data);
            end
        end
    end

    task automatic step();
        model_edge();
        @(negedge clk);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clr_inputs();
        ifc.req = '0; ifc.req_wr_strb = '0; ifc.req_rd_idx = '0; ifc.req_wr_idx = '0;
        ifc.req_wr_data = '0; ifc.req_attr = '0; ifc.err_clr = 1'b0;
    endtask

    task automatic set_slice(input int i, input logic [11:0] ri, input logic [11:0] wi,
                             input logic [31:0] wd, input logic [2:0] at);
        ifc.req_rd_idx[i*12 +: 12]  = ri;
        ifc.req_wr_idx[i*12 +: 12]  = wi;
        ifc.req_wr_data[i*32 +: 32] = wd;
        ifc.req_attr[i*3 +: 3]      = at;
    endtask

    function automatic logic [11:0] pick_idx();
        case ($urandom_range(2))
            0:       return REG_PRESENT_STATE;
            1:       return REG_NORM_INT_STAT;
            default: return 12'($urandom);
        endcase
    endfunction

    initial begin : stim
        int o;
        reset = 1'b1;
        clr_inputs();
        steps(2);
        reset = 1'b0;
        step();

        // All four contend; each owner releases after 3 granted cycles, then re-requests
        ifc.req = '1;
        step();
        for (int g = 0; g < 5; g++) begin
            o = (m_owner < 0) ? 0 : m_owner;
            steps(2);
            ifc.req[o] = 1'b0;
            step();
            ifc.req[o] = 1'b1;
            steps(2);
        end
        ifc.req = '0;
        steps(3);

        // Single requester 1 writes NORM_INT_STAT
        ifc.req = 4'b0010;
        set_slice(1, 12'h000, REG_NORM_INT_STAT, 32'h40, ATTR_RW1C);
        step();
        ifc.req_wr_strb[1] = 1'b1;
        step();
        ifc.req_wr_strb = '0;
        steps(3);
        ifc.req = '0;
        steps(3);

        // Non-owner write is dropped; new drop beats a simultaneous clear
        ifc.req = 4'b0001;
        steps(2);
        set_slice(2, 12'h000, REG_NORM_INT_STAT, 32'h1, ATTR_RW1C);
        ifc.req_wr_strb = 4'b0100;
        step();
        ifc.req_wr_strb = '0;
        step();
        ifc.err_clr = 1'b1;
        ifc.req_wr_strb = 4'b0100;
        step();
        ifc.req_wr_strb = '0;
        ifc.err_clr = 1'b0;
        step();
        ifc.err_clr = 1'b1;
        step();
        ifc.err_clr = 1'b0;
        ifc.req = '0;
        steps(3);

        // Requester 3 never lets go: revoked, locked out until req goes low
        ifc.req = 4'b1000;
        steps(14);
        ifc.req = '0;
        step();
        ifc.req = 4'b1000;
        steps(4);
        ifc.req = '0;
        steps(3);
        ifc.err_clr = 1'b1;
        step();
        ifc.err_clr = 1'b0;

        // Read PRESENT_STATE through the owner
        ifc.req = 4'b0010;
        set_slice(1, 12'h000, 12'h000, 32'h0, ATTR_RO);
        steps(2);
        set_slice(1, REG_PRESENT_STATE, 12'h000, 32'h0, ATTR_RO);
        steps(4);
        ifc.req = '0;
        steps(3);

        // Reset mid-session with a write in flight; pointer restarts at 0
        ifc.req = 4'b0010;
        set_slice(1, 12'h011, REG_NORM_INT_STAT, 32'hDEAD_BEEF, ATTR_RW);
        steps(2);
        ifc.req_wr_strb[1] = 1'b1;
        step();
        ifc.req_wr_strb = '0;
        reset = 1'b1;
        ifc.req = 4'b0101;
        step();
        reset = 1'b0;
        steps(4);
        ifc.req = '0;
        steps(3);

        // Randomized traffic: long-lived req levels, random strobes, clears and resets
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if ($urandom_range(7) == 0) ifc.req[i] = ~ifc.req[i];
                ifc.req_wr_strb[i] = ($urandom_range(3) == 0);
                set_slice(i, pick_idx(), pick_idx(), $urandom, 3'($urandom_range(7)));
            end
            ifc.err_clr = ($urandom_range(15) == 0);
            reset = ($urandom_range(199) == 0);
            step();
        end
        reset = 1'b0;
        clr_inputs();
        steps(4);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            n_chk++;
            n_err++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
